// File: rtl/blink_pkg.sv
// Shared types and helpers for the blink scheduler.
// BLINK_CTRL_ONESHOT_EN adds the ONESHOT repeat counter to the channel record.
package blink_pkg;
  localparam int BLINK_TICK_DIV_25M = 25000;
  // Stored phase-length width; holds any CW up to 16 without loss.
  localparam int BLINK_LW = 16;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } blink_mode_t;

  typedef enum logic {PH_OFF = 1'b0, PH_ON = 1'b1} blink_phase_t;
  typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} sweep_state_t;

  typedef struct packed {
    blink_mode_t         mode;
    blink_phase_t        phase;
    logic [BLINK_LW-1:0] rem;
`ifdef BLINK_CTRL_ONESHOT_EN
    logic [7:0]          cnt;
`endif
    logic [BLINK_LW-1:0] on_len;
    logic [BLINK_LW-1:0] off_len;
  } blink_ch_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [BLINK_LW-1:0] len_min1(input logic [BLINK_LW-1:0] v);
    return (v == '0) ? BLINK_LW'(1) : v;
  endfunction

  function automatic logic blink_level(input blink_ch_t c);
    return (c.mode == MODE_ON) ||
           ((c.mode == MODE_BLINK || c.mode == MODE_ONESHOT) && c.phase == PH_ON);
  endfunction
endpackage

// File: rtl/blink_ctrl_if.sv
// Channel configuration write port (valid/ready) for blink_ctrl.
interface blink_ctrl_if import blink_pkg::*; #(
  parameter int N_CH = 4,
  parameter int CW   = 8
);
  localparam int CHW = ch_w(N_CH);

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [1:0]     cfg_mode;
  logic [CW-1:0]  cfg_on;
  logic [CW-1:0]  cfg_off;
  logic [7:0]     cfg_count;

  modport master (output cfg_valid, cfg_ch, cfg_mode, cfg_on, cfg_off, cfg_count,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_ch, cfg_mode, cfg_on, cfg_off, cfg_count,
                  output cfg_ready);
endinterface

// File: rtl/blink_prescaler.sv
// Free-running 0..TICK_DIV-1 counter; tick is high for the single terminal count cycle.
module blink_prescaler #(
  parameter int TICK_DIV = 25000
) (
  input  logic CLOCK_25M,
  input  logic RST_N,
  output logic tick
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] cnt;

  assign tick = (cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge CLOCK_25M or negedge RST_N) begin
    if (!RST_N)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + PW'(1);
  end
endmodule

// File: rtl/blink_ctrl.sv
// Multi-channel blink scheduler: a ms prescaler plus one shared channel datapath swept after each tick.
// Define BLINK_CTRL_ONESHOT_EN to build ONESHOT counting and the done pulses.
module blink_ctrl import blink_pkg::*; #(
  parameter int N_CH     = 4,
  parameter int TICK_DIV = BLINK_TICK_DIV_25M,
  parameter int CW       = 8
) (
  input  logic            CLOCK_25M,
  input  logic            RST_N,
  blink_ctrl_if.slave     cfg,
  output logic [N_CH-1:0] blink,
  output logic [N_CH-1:0] done
);
  localparam int CHW = ch_w(N_CH);

  logic           tick;
  sweep_state_t   state;
  logic [CHW-1:0] idx;
  blink_ch_t      ch [N_CH];
  blink_ch_t      cur, nxt, wr_ch;
  logic [CW-1:0]  on_in, off_in;
  logic           wr;

  blink_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .CLOCK_25M(CLOCK_25M),
    .RST_N    (RST_N),
    .tick     (tick)
  );

  // Writes are only taken while idle and off-tick, so they never race the sweep.
  assign cfg.cfg_ready = (state == S_IDLE) && !tick;
  assign wr            = cfg.cfg_valid && cfg.cfg_ready && (int'(cfg.cfg_ch) < N_CH);
  assign on_in         = cfg.cfg_on;
  assign off_in        = cfg.cfg_off;

  always_comb begin
    wr_ch         = '0;
    wr_ch.mode    = blink_mode_t'(cfg.cfg_mode);
    wr_ch.phase   = PH_ON;
    wr_ch.on_len  = len_min1(BLINK_LW'(on_in));
    wr_ch.off_len = len_min1(BLINK_LW'(off_in));
    wr_ch.rem     = wr_ch.on_len;
`ifdef BLINK_CTRL_ONESHOT_EN
    wr_ch.cnt     = (cfg.cfg_count == 8'd0) ? 8'd1 : cfg.cfg_count;
`endif
  end

`ifdef BLINK_CTRL_ONESHOT_EN
  logic            nxt_fin;
  logic [N_CH-1:0] done_q;
  assign done = done_q;
`else
  logic unused_count;
  assign unused_count = ^cfg.cfg_count;
  assign done = '0;
`endif

  // Shared next-state datapath for the channel currently under the sweep index.
  always_comb begin
    cur = ch[idx];
    nxt = cur;
`ifdef BLINK_CTRL_ONESHOT_EN
    nxt_fin = 1'b0;
`endif
    if (cur.mode == MODE_BLINK || cur.mode == MODE_ONESHOT) begin
      if (cur.rem > BLINK_LW'(1)) begin
        nxt.rem = cur.rem - BLINK_LW'(1);
      end else if (cur.phase == PH_ON) begin
        nxt.phase = PH_OFF;
        nxt.rem   = cur.off_len;
      end else begin
        nxt.phase = PH_ON;
        nxt.rem   = cur.on_len;
`ifdef BLINK_CTRL_ONESHOT_EN
        if (cur.mode == MODE_ONESHOT) begin
          nxt.cnt = cur.cnt - 8'd1;
          // Last cycle finished: park in OFF instead of re-entering ON.
          if (cur.cnt <= 8'd1) begin
            nxt.mode  = MODE_OFF;
            nxt.phase = PH_OFF;
            nxt_fin   = 1'b1;
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge CLOCK_25M or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      idx   <= '0;
      blink <= '0;
      for (int i = 0; i < N_CH; i++) ch[i] <= '0;
`ifdef BLINK_CTRL_ONESHOT_EN
      done_q <= '0;
`endif
    end else begin
`ifdef BLINK_CTRL_ONESHOT_EN
      done_q <= '0;
`endif
      case (state)
        S_IDLE: begin
          if (tick) begin
            state <= S_SWEEP;
            idx   <= '0;
          end
          if (wr) begin
            ch[cfg.cfg_ch]    <= wr_ch;
            blink[cfg.cfg_ch] <= blink_level(wr_ch);
          end
        end
        S_SWEEP: begin
          ch[idx]    <= nxt;
          blink[idx] <= blink_level(nxt);
`ifdef BLINK_CTRL_ONESHOT_EN
          done_q[idx] <= nxt_fin;
`endif
          if (idx == CHW'(N_CH - 1)) state <= S_IDLE;
          else                       idx   <= idx + CHW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blink_ctrl.sv
// Directed bench for blink_ctrl with four channels and a six-cycle tick,
// the smallest divider that leaves an idle write slot after a four-channel sweep.
module tb_blink_ctrl;
  import blink_pkg::*;

  localparam int NCH  = 4;
  localparam int TDIV = 6;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] blink, done;
  int             checks = 0;
  int             errors = 0;
  int             pc;
  logic [NCH-1:0] sb [0:79];
  logic [NCH-1:0] sd [0:79];

  blink_ctrl_if #(.N_CH(NCH), .CW(8)) cif();

  blink_ctrl #(.N_CH(NCH), .TICK_DIV(TDIV), .CW(8)) dut (
    .CLOCK_25M(clk),
    .RST_N    (rst_n),
    .cfg      (cif),
    .blink    (blink),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference prescaler phase: tick falls on pc == TDIV-1, the only write slot after a sweep is pc == 4.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= 0;
    else        pc <= (pc == TDIV - 1) ? 0 : pc + 1;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cif.cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_pc(input int v);
    for (int n = 0; n < 2 * TDIV && pc != v; n++) @(negedge clk);
  endtask

  // Called on a falling edge; returns on the falling edge of the cycle after the handshake.
  task automatic cfg_write(input int ch, input int mode, input int on, input int off, input int cnt);
    int n = 0;
    cif.cfg_valid = 1'b1;
    cif.cfg_ch    = 2'(ch);
    cif.cfg_mode  = 2'(mode);
    cif.cfg_on    = 8'(on);
    cif.cfg_off   = 8'(off);
    cif.cfg_count = 8'(cnt);
    while (!cif.cfg_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (cif.cfg_ready !== 1'b1) begin
      errors++; $display("FAIL cfg_write_timeout ch%0d ready=%b want 1", ch, cif.cfg_ready);
    end
    @(negedge clk);
    cif.cfg_valid = 1'b0;
  endtask

  // Sample k=1 is the current falling edge.
  task automatic capture(input int ncyc);
    for (int k = 1; k <= ncyc; k++) begin
      if (k > 1) @(negedge clk);
      sb[k] = blink;
      sd[k] = done;
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    do_reset();
    checks++; if (blink !== 4'b0000) begin errors++; $display("FAIL reset_blink got %b want 0000", blink); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done got %b want 0000", done); end
    checks++; if (cif.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cif.cfg_ready); end
    wait_pc(4);
    cfg_write(0, MODE_ON, 0, 0, 0);
    @(negedge clk);   // sweep is now in progress
    checks++; if (blink[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_on got %b want 1", blink[0]); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (blink !== 4'b0000 || done !== 4'b0000 || cif.cfg_ready !== 1'b1) begin
      errors++; $display("FAIL midsweep_reset blink=%b done=%b ready=%b want 0000 0000 1", blink, done, cif.cfg_ready);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (blink !== 4'b0000 || cif.cfg_ready !== 1'b1) bad++;
    end
    rst_n = 1'b1;
    capture(20);
    for (int k = 1; k <= 20; k++) if (sb[k] !== 4'b0000) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_hold_and_release bad_cycles=%0d want 0", bad); end
  endtask

  task automatic test_blink();
    int bad = 0;
    int pts [9] = '{1, 10, 11, 28, 29, 40, 41, 58, 59};
    logic exp_pt [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    wait_pc(4);
    cfg_write(2, MODE_BLINK, 2, 3, 0);
    capture(60);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (sb[pts[i]][2] !== exp_pt[i]) begin
        errors++; $display("FAIL blink_ch2_c%0d got %b want %b", pts[i], sb[pts[i]][2], exp_pt[i]);
      end
    end
    for (int k = 1; k <= 60; k++) if ((sb[k] & 4'b1011) !== 4'b0000 || sd[k] !== 4'b0000) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL blink_others_quiet bad_cycles=%0d want 0", bad); end
  endtask

  task automatic test_oneshot();
    int ndone = 0;
    logic e;
    do_reset();
    wait_pc(4);
    cfg_write(0, MODE_ONESHOT, 1, 1, 2);
    capture(40);
    for (int k = 1; k <= 40; k++) begin
`ifdef BLINK_CTRL_ONESHOT_EN
      e = (k <= 2) || (k >= 9 && k <= 14);
`else
      e = ((k + 3) % 12) < 6;
`endif
      checks++;
      if (sb[k][0] !== e) begin errors++; $display("FAIL oneshot_blink_c%0d got %b want %b", k, sb[k][0], e); end
      if (sd[k] !== 4'b0000) ndone++;
    end
`ifdef BLINK_CTRL_ONESHOT_EN
    checks++; if (sd[21] !== 4'b0001) begin errors++; $display("FAIL oneshot_done_c21 got %b want 0001", sd[21]); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL oneshot_done_count got %0d want 1", ndone); end
`else
    checks++; if (ndone != 0) begin errors++; $display("FAIL oneshot_done_tied got %0d want 0", ndone); end
`endif
  endtask

  task automatic test_handshake();
    int nhs = 0;
    int bad = 0;
    do_reset();
    wait_pc(5);
    cif.cfg_valid = 1'b1; cif.cfg_ch = 2'd1; cif.cfg_mode = 2'(MODE_ON);
    cif.cfg_on = 8'd0; cif.cfg_off = 8'd0; cif.cfg_count = 8'd0;
    checks++; if (cif.cfg_ready !== 1'b0) begin errors++; $display("FAIL hs_tick_ready got %b want 0", cif.cfg_ready); end
    for (int k = 0; k < NCH; k++) begin
      @(negedge clk);
      if (cif.cfg_ready !== 1'b0 || blink[1] !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hs_sweep_blocked bad_cycles=%0d want 0", bad); end
    @(negedge clk);
    checks++; if (cif.cfg_ready !== 1'b1) begin errors++; $display("FAIL hs_first_ready got %b want 1", cif.cfg_ready); end
    if (cif.cfg_valid && cif.cfg_ready) nhs++;
    @(negedge clk);
    if (cif.cfg_valid && cif.cfg_ready) nhs++;
    cif.cfg_valid = 1'b0;
    checks++; if (blink[1] !== 1'b1) begin errors++; $display("FAIL hs_landed got %b want 1", blink[1]); end
    checks++; if (nhs != 1) begin errors++; $display("FAIL hs_once got %0d want 1", nhs); end
  endtask

  task automatic test_zero_len();
    int ndone = 0;
    do_reset();
    wait_pc(4);
    cfg_write(3, MODE_BLINK, 0, 0, 0);
    capture(20);
    checks++; if (sb[5][3] !== 1'b1 || sb[6][3] !== 1'b0) begin
      errors++; $display("FAIL zero_len_first_flip got %b%b want 10", sb[5][3], sb[6][3]);
    end
    checks++; if (sb[11][3] !== 1'b0 || sb[12][3] !== 1'b1 || sb[17][3] !== 1'b1 || sb[18][3] !== 1'b0) begin
      errors++; $display("FAIL zero_len_toggle got %b%b%b%b want 0110", sb[11][3], sb[12][3], sb[17][3], sb[18][3]);
    end
    do_reset();
    wait_pc(4);
    cfg_write(1, MODE_ONESHOT, 1, 1, 0);
    capture(24);
    for (int k = 1; k <= 24; k++) if (sd[k] !== 4'b0000) ndone++;
    checks++; if (sb[3][1] !== 1'b1 || sb[4][1] !== 1'b0) begin
      errors++; $display("FAIL zero_cnt_on_phase got %b%b want 10", sb[3][1], sb[4][1]);
    end
`ifdef BLINK_CTRL_ONESHOT_EN
    checks++; if (sd[10] !== 4'b0010 || ndone != 1) begin
      errors++; $display("FAIL zero_cnt_done got %b count %0d want 0010 count 1", sd[10], ndone);
    end
    checks++; if (sb[10][1] !== 1'b0 || sb[20][1] !== 1'b0) begin
      errors++; $display("FAIL zero_cnt_final_off got %b%b want 00", sb[10][1], sb[20][1]);
    end
`else
    checks++; if (sb[10][1] !== 1'b1 || ndone != 0) begin
      errors++; $display("FAIL zero_cnt_as_blink got %b count %0d want 1 count 0", sb[10][1], ndone);
    end
`endif
  endtask

  task automatic test_restart();
    int bad = 0;
    do_reset();
    wait_pc(4);
    cfg_write(1, MODE_BLINK, 1, 3, 0);
    wait_pc(4);
    checks++; if (blink[1] !== 1'b0) begin errors++; $display("FAIL restart_mid_off got %b want 0", blink[1]); end
    cfg_write(1, MODE_ON, 0, 0, 0);
    checks++; if (blink[1] !== 1'b1) begin errors++; $display("FAIL restart_next_cycle got %b want 1", blink[1]); end
    for (int k = 0; k < 10 * TDIV; k++) begin
      @(negedge clk);
      if (blink !== 4'b0010) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL restart_hold_on bad_cycles=%0d want 0", bad); end
  endtask

  initial begin
    cif.cfg_valid = 1'b0;
    cif.cfg_ch    = '0;
    cif.cfg_mode  = '0;
    cif.cfg_on    = '0;
    cif.cfg_off   = '0;
    cif.cfg_count = '0;
    test_reset();
    test_blink();
    test_oneshot();
    test_handshake();
    test_zero_len();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
